// File: rtl/elmnt_wise_seq.sv
// Chunked sequencer for the N_REG-lane element-wise Q-format multiplier bank:
// fetches a/w chunks from SRAM, registers the lane products, writes them back.
module elmnt_wise_seq #(
    parameter int WIDTH = 32,
    parameter int N_REG = 31,
    parameter int AW    = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [AW-1:0]          a_base,
    input  logic [AW-1:0]          w_base,
    input  logic [AW-1:0]          y_base,
    input  logic [AW-1:0]          len,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [AW-1:0]          a_addr,
    output logic [AW-1:0]          w_addr,
    input  logic [WIDTH-1:0]       a_rdata,
    input  logic [WIDTH-1:0]       w_rdata,
    output logic [N_REG*WIDTH-1:0] all_a,
    output logic [N_REG*WIDTH-1:0] all_w,
    input  logic [N_REG*WIDTH-1:0] all_mult,
    output logic                   wr_en,
    output logic [AW-1:0]          y_addr,
    output logic [WIDTH-1:0]       y_wdata
);

    typedef enum logic [2:0] {IDLE, FETCH, MULT, WRITE, FIN} state_t;

    state_t                       state;
    logic [AW-1:0]                a_b, w_b, y_b;
    logic [AW-1:0]                rem, off, n, cnt;
    logic [N_REG-1:0][WIDTH-1:0]  op_a, op_w, res;
    logic [N_REG-1:0][WIDTH-1:0]  mult_v;
    logic [AW-1:0]                rem_after, off_next, n_next, n_start;

    function automatic logic [AW-1:0] chunk(input logic [AW-1:0] r);
        return (r > AW'(N_REG)) ? AW'(N_REG) : r;
    endfunction

    assign all_a     = op_a;
    assign all_w     = op_w;
    assign mult_v    = all_mult;
    assign rem_after = rem - n;
    assign off_next  = off + AW'(N_REG);
    assign n_next    = chunk(rem_after);
    assign n_start   = chunk(len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            wr_en   <= 1'b0;
            a_addr  <= '0;
            w_addr  <= '0;
            y_addr  <= '0;
            y_wdata <= '0;
            a_b     <= '0;
            w_b     <= '0;
            y_b     <= '0;
            rem     <= '0;
            off     <= '0;
            n       <= '0;
            cnt     <= '0;
            op_a    <= '0;
            op_w    <= '0;
            res     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_b  <= a_base;
                    w_b  <= w_base;
                    y_b  <= y_base;
                    rem  <= len;
                    off  <= '0;
                    n    <= n_start;
                    cnt  <= '0;
                    busy <= 1'b1;
                    if (len != '0) begin
                        state  <= FETCH;
                        rd_en  <= 1'b1;
                        a_addr <= a_base;
                        w_addr <= w_base;
                        for (int unsigned g = 0; g < N_REG; g++)
                            if (AW'(g) >= n_start) begin
                                op_a[g] <= '0;
                                op_w[g] <= '0;
                            end
                    end else begin
                        // empty job: one zero-length WRITE pass, then FIN
                        state <= WRITE;
                    end
                end
                FETCH: begin
                    for (int unsigned g = 0; g < N_REG; g++)
                        if (AW'(g + 1) == cnt) begin
                            op_a[g] <= a_rdata;
                            op_w[g] <= w_rdata;
                        end
                    cnt    <= cnt + AW'(1);
                    a_addr <= a_addr + AW'(1);
                    w_addr <= w_addr + AW'(1);
                    rd_en  <= (cnt + AW'(1) < n);
                    if (cnt == n) state <= MULT;
                end
                MULT: begin
                    for (int unsigned g = 0; g < N_REG; g++)
                        res[g] <= (AW'(g) < n) ? mult_v[g] : '0;
                    state   <= WRITE;
                    cnt     <= '0;
                    wr_en   <= 1'b1;
                    y_addr  <= y_b + off;
                    y_wdata <= mult_v[0];
                end
                WRITE: begin
                    if (cnt + AW'(1) < n) begin
                        cnt    <= cnt + AW'(1);
                        y_addr <= y_addr + AW'(1);
                        for (int unsigned g = 0; g < N_REG; g++)
                            if (AW'(g) == cnt + AW'(1)) y_wdata <= res[g];
                    end else begin
                        wr_en <= 1'b0;
                        rem   <= rem_after;
                        if (rem_after != '0) begin
                            state  <= FETCH;
                            off    <= off_next;
                            n      <= n_next;
                            cnt    <= '0;
                            rd_en  <= 1'b1;
                            a_addr <= a_b + off_next;
                            w_addr <= w_b + off_next;
                            for (int unsigned g = 0; g < N_REG; g++)
                                if (AW'(g) >= n_next) begin
                                    op_a[g] <= '0;
                                    op_w[g] <= '0;
                                end
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elmnt_wise_seq.sv
// Bench for elmnt_wise_seq: SRAM models, Q8.24 multiplier stub, queue scoreboard.
module tb_elmnt_wise_seq;

    localparam int WIDTH = 32;
    localparam int N_REG = 4;
    localparam int AW    = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [AW-1:0]    a_base, w_base, y_base, len;
    logic             busy, done, rd_en, wr_en;
    logic [AW-1:0]    a_addr, w_addr, y_addr;
    logic [WIDTH-1:0] a_rdata, w_rdata, y_wdata;
    logic [N_REG*WIDTH-1:0] all_a, all_w, all_mult;

    logic [WIDTH-1:0] a_mem [256];
    logic [WIDTH-1:0] w_mem [256];
    logic [WIDTH-1:0] y_mem [256];

    logic [15:0] rq[$];
    logic [39:0] wq[$];
    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    elmnt_wise_seq #(.WIDTH(WIDTH), .N_REG(N_REG), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_base(a_base), .w_base(w_base), .y_base(y_base), .len(len),
        .busy(busy), .done(done), .rd_en(rd_en),
        .a_addr(a_addr), .w_addr(w_addr), .a_rdata(a_rdata), .w_rdata(w_rdata),
        .all_a(all_a), .all_w(all_w), .all_mult(all_mult),
        .wr_en(wr_en), .y_addr(y_addr), .y_wdata(y_wdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] w);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{w[31]}}, w});
        return p[55:24];
    endfunction

    always_comb begin
        all_mult = '0;
        for (int g = 0; g < N_REG; g++)
            all_mult[g*WIDTH +: WIDTH] = qmul(all_a[g*WIDTH +: WIDTH], all_w[g*WIDTH +: WIDTH]);
    end

    always @(posedge clk) begin
        if (rd_en) begin
            a_rdata <= a_mem[a_addr];
            w_rdata <= w_mem[w_addr];
        end
        if (wr_en) y_mem[y_addr] <= y_wdata;
    end

    task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            check("rd_wr_exclusive", {299'd0, rd_en & wr_en}, '0);
            if (rd_en) begin
                if (rq.size() == 0) begin
                    bad++; total++;
                    $display("FAIL rd_unexpected: got a=%0h w=%0h expected none", a_addr, w_addr);
                end else check("rd_addr", {284'd0, a_addr, w_addr}, {284'd0, rq.pop_front()});
            end
            if (wr_en) begin
                if (wq.size() == 0) begin
                    bad++; total++;
                    $display("FAIL wr_unexpected: got y=%0h d=%0h expected none", y_addr, y_wdata);
                end else check("wr_addr_data", {260'd0, y_addr, y_wdata}, {260'd0, wq.pop_front()});
            end
        end
    end

    task automatic run_job(input logic [7:0] ab, input logic [7:0] wb, input logic [7:0] yb,
                           input logic [7:0] ln, input bit glitch);
        int exp_lat, lat, bc, rem, nc, d0, nl;
        bit seen;
        exp_lat = 1;
        rem = int'(ln);
        while (rem > 0) begin
            nc = (rem > N_REG) ? N_REG : rem;
            exp_lat += 2 * nc + 2;
            rem -= nc;
        end
        if (ln == 0) exp_lat = 2;
        for (int i = 0; i < int'(ln); i++) begin
            logic [7:0] ai, wi, yi;
            ai = ab + 8'(i); wi = wb + 8'(i); yi = yb + 8'(i);
            rq.push_back({ai, wi});
            wq.push_back({yi, qmul(a_mem[ai], w_mem[wi])});
        end
        d0 = done_cnt;
        a_base = ab; w_base = wb; y_base = yb; len = ln; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_base = 8'($urandom); w_base = 8'($urandom); y_base = 8'($urandom); len = 8'($urandom);
        lat = 1; bc = 0; seen = 0;
        forever begin
            if (busy) bc++;
            if (done) begin seen = 1; break; end
            if (lat >= 400) break;
            start = glitch && (lat == 2);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("done_seen", {299'd0, seen}, {299'd0, 1'b1});
        check("latency", 300'(lat), 300'(exp_lat));
        check("busy_cycles", 300'(bc), 300'(exp_lat));
        if (ln != 0) begin
            nl = int'(ln) - N_REG * ((int'(ln) - 1) / N_REG);
            for (int g = nl; g < N_REG; g++)
                check("unused_lane_zero", {236'd0, all_a[g*WIDTH +: WIDTH], all_w[g*WIDTH +: WIDTH]}, '0);
        end
        if (glitch) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_done", {299'd0, busy}, '0);
        repeat (3) @(negedge clk);
        check("done_once", 300'(done_cnt - d0), 300'(1));
        check("busy_idle", {299'd0, busy}, '0);
        check("queues_drained", 300'(rq.size() + wq.size()), '0);
    endtask

    task automatic check_all_zero();
        check("zero_ctl", {296'd0, busy, done, rd_en, wr_en}, '0);
        check("zero_addr", {276'd0, a_addr, w_addr, y_addr}, '0);
        check("zero_data", {12'd0, y_wdata, all_a, all_w}, '0);
    endtask

    initial begin
        int d0;
        bit hit;
        rst_n = 1'b0; start = 1'b0;
        a_base = '0; w_base = '0; y_base = '0; len = '0;
        for (int i = 0; i < 256; i++) begin
            a_mem[i] = $urandom; w_mem[i] = $urandom; y_mem[i] = '0;
        end
        repeat (2) @(negedge clk);
        check_all_zero();
        rst_n = 1'b1;
        @(negedge clk);

        // worked example with fixed Q values
        a_mem[8'h10] = 32'h0100_0000; a_mem[8'h11] = 32'h0200_0000;
        a_mem[8'h12] = 32'hFF00_0000; a_mem[8'h13] = 32'h0080_0000;
        w_mem[8'h20] = 32'h0080_0000; w_mem[8'h21] = 32'h0080_0000;
        w_mem[8'h22] = 32'h0300_0000; w_mem[8'h23] = 32'h0400_0000;
        run_job(8'h10, 8'h20, 8'h40, 8'd4, 1'b0);
        check("ex1_y0", 300'(y_mem[8'h40]), 300'(32'h0080_0000));
        check("ex1_y1", 300'(y_mem[8'h41]), 300'(32'h0100_0000));
        check("ex1_y2", 300'(y_mem[8'h42]), 300'(32'hFD00_0000));
        check("ex1_y3", 300'(y_mem[8'h43]), 300'(32'h0200_0000));

        // three chunks, partial last chunk
        for (int i = 0; i < 10; i++) begin
            a_mem[8'h50 + 8'(i)] = 32'(i);
            w_mem[8'h70 + 8'(i)] = 32'h0100_0000;
        end
        run_job(8'h50, 8'h70, 8'h80, 8'd10, 1'b0);
        for (int i = 0; i < 10; i++)
            check("ex2_y", 300'(y_mem[8'h80 + 8'(i)]), 300'(i));

        run_job(8'h00, 8'h00, 8'h00, 8'd0, 1'b0);
        run_job(8'h30, 8'h31, 8'h90, 8'd6, 1'b1);

        // async reset in the middle of a write burst
        for (int i = 0; i < 8; i++) begin
            rq.push_back({8'h60 + 8'(i), 8'h68 + 8'(i)});
            wq.push_back({8'hB0 + 8'(i), qmul(a_mem[8'h60 + 8'(i)], w_mem[8'h68 + 8'(i)])});
        end
        d0 = done_cnt;
        a_base = 8'h60; w_base = 8'h68; y_base = 8'hB0; len = 8'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            hit = wr_en;
        end
        check("reset_reach_write", {299'd0, hit}, {299'd0, 1'b1});
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero();
        rq.delete(); wq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_no_done", 300'(done_cnt), 300'(d0));
        run_job(8'h60, 8'h68, 8'hB0, 8'd8, 1'b0);

        run_job(8'hFE, 8'h05, 8'hA0, 8'd4, 1'b0);

        for (int t = 0; t < 8; t++)
            run_job(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 20)), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
